// File: rtl/valu_arbiter_pkg.sv
// Shared definitions for the vector-ALU arbiter: default widths and ALU opcodes.
package valu_arbiter_pkg;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_NUM_ELEM   = 8;
  localparam int DEF_REG_WIDTH  = 256;
  localparam int DEF_ELEM_WIDTH = 32;
  localparam int DEF_TAG_W      = 3;

  typedef logic [2:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD = 3'b000;
  localparam alu_ctrl_t ALU_SUB = 3'b001;
  localparam alu_ctrl_t ALU_REP = 3'b010;
  localparam alu_ctrl_t ALU_MUL = 3'b011;
  localparam alu_ctrl_t ALU_SLL = 3'b100;
  localparam alu_ctrl_t ALU_SLT = 3'b101;

endpackage

// File: rtl/valu_arbiter_if.sv
// Request/response bundle between the requesters (master) and the shared ALU arbiter (slave).
interface valu_arbiter_if import valu_arbiter_pkg::*; #(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int REG_WIDTH = DEF_REG_WIDTH
) ();

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*REG_WIDTH-1:0] req_a;
  logic [NUM_REQ*REG_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]           req_use_imm;
  logic [NUM_REQ*3-1:0]         req_alu_ctrl;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [NUM_REQ-1:0]           rsp_ready;
  logic [NUM_REQ*REG_WIDTH-1:0] rsp_result;
  logic [NUM_REQ-1:0]           rsp_zero;
  logic                         busy;

  modport master (
    output req_valid, req_a, req_b, req_use_imm, req_alu_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_use_imm, req_alu_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, busy
  );

endinterface

// File: rtl/valu_arbiter_alu.sv
// Combinational lane-parallel vector ALU; lanes are independent, Zero flags an all-zero result.
module ALU import valu_arbiter_pkg::*; #(
  parameter int NUM_ELEM   = DEF_NUM_ELEM,
  parameter int ELEM_WIDTH = DEF_ELEM_WIDTH,
  parameter int REG_WIDTH  = DEF_REG_WIDTH
) (
  input  logic [REG_WIDTH-1:0] i_a,
  input  logic [REG_WIDTH-1:0] i_b,
  input  alu_ctrl_t            i_alu_ctrl,
  output logic [REG_WIDTH-1:0] o_result,
  output logic                 o_zero
);

  localparam int SH_W = $clog2(ELEM_WIDTH);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ELEM; gi++) begin : g_lane
      logic [ELEM_WIDTH-1:0] w_a;
      logic [ELEM_WIDTH-1:0] w_b;
      logic [ELEM_WIDTH-1:0] w_r;

      assign w_a = i_a[gi*ELEM_WIDTH +: ELEM_WIDTH];
      assign w_b = i_b[gi*ELEM_WIDTH +: ELEM_WIDTH];

      // Multiply keeps the low lane-width bits; slt is a signed compare.
      always_comb begin
        case (i_alu_ctrl)
          ALU_ADD: w_r = w_a + w_b;
          ALU_SUB: w_r = w_a - w_b;
          ALU_REP: w_r = w_b;
          ALU_MUL: w_r = w_a * w_b;
          ALU_SLL: w_r = w_a << w_b[SH_W-1:0];
          ALU_SLT: w_r = {{(ELEM_WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
          default: w_r = '0;
        endcase
      end

      assign o_result[gi*ELEM_WIDTH +: ELEM_WIDTH] = w_r;
    end
  endgenerate

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/valu_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible index at or above the pointer.
module rr_arbiter import valu_arbiter_pkg::*; #(
  parameter int N = DEF_NUM_REQ
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_eligible,
  output logic [N-1:0] o_grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]  r_ptr;
  logic [PW-1:0]  w_ptr_next;
  logic [PW-1:0]  w_gidx;
  logic [2*N-1:0] w_elig_dbl;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_seen;
  logic [N-1:0]   w_first;
  logic [2*N-1:0] w_grant_dbl;
  logic           w_any;

  // Rotate so the pointer lands on bit 0, keep the lowest set bit, rotate back.
  assign w_elig_dbl  = {i_eligible, i_eligible};
  assign w_rot       = N'(w_elig_dbl >> r_ptr);
  assign w_grant_dbl = {w_first, w_first} << r_ptr;
  assign o_grant     = N'(w_grant_dbl >> N);
  assign w_any       = |i_eligible;

  genvar gi, gb;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pick
      if (gi == 0) begin : g_lsb
        assign w_seen[gi] = 1'b0;
      end else begin : g_rest
        assign w_seen[gi] = |w_rot[gi-1:0];
      end
      assign w_first[gi] = w_rot[gi] & ~w_seen[gi];
    end

    for (gb = 0; gb < PW; gb++) begin : g_enc
      logic [N-1:0] w_mask;
      for (gi = 0; gi < N; gi++) begin : g_bit
        assign w_mask[gi] = 1'(gi >> gb);
      end
      assign w_gidx[gb] = |(o_grant & w_mask);
    end
  endgenerate

  always_comb begin
    w_ptr_next = r_ptr;
    if (w_any) begin
      if (w_gidx == PW'(N - 1)) w_ptr_next = '0;
      else                      w_ptr_next = w_gidx + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else     r_ptr <= w_ptr_next;
  end

endmodule

// File: rtl/valu_arbiter.sv
// Shares one vector ALU among NUM_REQ requesters: RR grant, one execute register, per-requester result slots.
module valu_arbiter import valu_arbiter_pkg::*; #(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int NUM_ELEM   = DEF_NUM_ELEM,
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int ELEM_WIDTH = DEF_ELEM_WIDTH,
  parameter int TAG_W      = DEF_TAG_W
) (
  input  logic          clk,
  input  logic          rst,
  valu_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0]   w_outst;
  logic [NUM_REQ-1:0]   w_elig;
  logic [NUM_REQ-1:0]   w_grant;
  logic [REG_WIDTH-1:0] w_sel_a;
  logic [REG_WIDTH-1:0] w_sel_b;
  logic                 w_sel_imm;
  alu_ctrl_t            w_sel_ctrl;
  logic [TAG_W-1:0]     w_sel_tag;

  logic                 r_ex_valid;
  logic [REG_WIDTH-1:0] r_ex_a;
  logic [REG_WIDTH-1:0] r_ex_b;
  logic                 r_ex_imm;
  alu_ctrl_t            r_ex_ctrl;
  logic [TAG_W-1:0]     r_ex_tag;

  logic [REG_WIDTH-1:0] w_b_eff;
  logic [REG_WIDTH-1:0] w_alu_res;
  logic                 w_alu_zero;

  // A requester with a result still unconsumed is excluded, so its slot is always free on arrival.
  assign w_elig        = bus.req_valid & ~w_outst;
  assign bus.req_ready = w_grant;
  assign bus.busy      = r_ex_valid | (|w_outst);

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk        (clk),
    .rst        (rst),
    .i_eligible (w_elig),
    .o_grant    (w_grant)
  );

  always_comb begin
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_imm  = 1'b0;
    w_sel_ctrl = ALU_ADD;
    w_sel_tag  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a    = bus.req_a[i*REG_WIDTH +: REG_WIDTH];
        w_sel_b    = bus.req_b[i*REG_WIDTH +: REG_WIDTH];
        w_sel_imm  = bus.req_use_imm[i];
        w_sel_ctrl = bus.req_alu_ctrl[i*3 +: 3];
        w_sel_tag  = TAG_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid <= 1'b0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_imm   <= 1'b0;
      r_ex_ctrl  <= ALU_ADD;
      r_ex_tag   <= '0;
    end else begin
      r_ex_valid <= |w_grant;
      if (|w_grant) begin
        r_ex_a    <= w_sel_a;
        r_ex_b    <= w_sel_b;
        r_ex_imm  <= w_sel_imm;
        r_ex_ctrl <= w_sel_ctrl;
        r_ex_tag  <= w_sel_tag;
      end
    end
  end

  assign w_b_eff = r_ex_imm ? {NUM_ELEM{r_ex_b[ELEM_WIDTH-1:0]}} : r_ex_b;

  ALU #(
    .NUM_ELEM   (NUM_ELEM),
    .ELEM_WIDTH (ELEM_WIDTH),
    .REG_WIDTH  (REG_WIDTH)
  ) u_alu (
    .i_a        (r_ex_a),
    .i_b        (w_b_eff),
    .i_alu_ctrl (r_ex_ctrl),
    .o_result   (w_alu_res),
    .o_zero     (w_alu_zero)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      logic                 r_valid;
      logic [REG_WIDTH-1:0] r_result;
      logic                 r_zero;
      logic                 r_outst;
      logic                 w_load;
      logic                 w_take;

      assign w_load = r_ex_valid && (r_ex_tag == TAG_W'(gi));
      assign w_take = r_valid && bus.rsp_ready[gi];

      // Result stays put after consumption; only the valid bit drops.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid  <= 1'b0;
          r_result <= '0;
          r_zero   <= 1'b0;
          r_outst  <= 1'b0;
        end else begin
          if (w_load) begin
            r_valid  <= 1'b1;
            r_result <= w_alu_res;
            r_zero   <= w_alu_zero;
          end else if (w_take) begin
            r_valid  <= 1'b0;
          end
          if (w_grant[gi])  r_outst <= 1'b1;
          else if (w_take)  r_outst <= 1'b0;
        end
      end

      assign bus.rsp_valid[gi]                         = r_valid;
      assign bus.rsp_result[gi*REG_WIDTH +: REG_WIDTH] = r_result;
      assign bus.rsp_zero[gi]                          = r_zero;
      assign w_outst[gi]                               = r_outst;
    end
  endgenerate

endmodule

// File: tb/tb_valu_arbiter.sv
// Directed bench for valu_arbiter with a cycle-level reference model checked every cycle.
module tb_valu_arbiter;
  import valu_arbiter_pkg::*;

  localparam int NR = 2;
  localparam int NE = 8;
  localparam int EW = 32;
  localparam int RW = 256;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  valu_arbiter_if #(.NUM_REQ(NR), .REG_WIDTH(RW)) vif ();

  valu_arbiter #(
    .NUM_REQ(NR), .NUM_ELEM(NE), .REG_WIDTH(RW), .ELEM_WIDTH(EW), .TAG_W(TW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] splat(input logic [31:0] v);
    return {NE{v}};
  endfunction

  // Reference ALU: per-lane arithmetic on plain integers; bit RW is the Zero flag.
  function automatic logic [RW:0] alu_model(input logic [RW-1:0] a, input logic [RW-1:0] b,
                                            input logic imm, input logic [2:0] op);
    logic [RW-1:0] r;
    int unsigned x, y, z;
    int sx, sy;
    r = '0;
    for (int l = 0; l < NE; l++) begin
      x = a[l*EW +: EW];
      y = imm ? b[EW-1:0] : b[l*EW +: EW];
      sx = int'(x);
      sy = int'(y);
      case (op)
        3'd0:    z = x + y;
        3'd1:    z = x - y;
        3'd2:    z = y;
        3'd3:    z = x * y;
        3'd4:    z = x << (y % 32);
        3'd5:    z = (sx < sy) ? 1 : 0;
        default: z = 0;
      endcase
      r[l*EW +: EW] = z;
    end
    return {(r == '0), r};
  endfunction

  // Model state as it stands during the current cycle.
  bit [NR-1:0]   m_outst = '0;
  bit [NR-1:0]   m_vld   = '0;
  logic [RW-1:0] m_res [NR];
  bit [NR-1:0]   m_zero  = '0;
  int            m_ptr   = 0;
  bit            m_ex_v  = 1'b0;
  int            m_ex_tag = 0;
  logic [RW:0]   m_ex_out = '0;
  int            mg, midx;
  logic [NR-1:0] meg;

  initial for (int i = 0; i < NR; i++) m_res[i] = '0;

  always @(negedge clk) begin
    cyc++;
    mg = -1;
    for (int k = 0; k < NR; k++) begin
      midx = (m_ptr + k) % NR;
      if (mg < 0 && vif.req_valid[midx] && !m_outst[midx]) mg = midx;
    end
    meg = '0;
    if (mg >= 0) meg[mg] = 1'b1;

    if (chk_en) begin
      chk("req_ready", RW'(vif.req_ready), RW'(meg));
      chk("busy", RW'(vif.busy), RW'(m_ex_v || (|m_outst)));
      for (int i = 0; i < NR; i++) begin
        chk($sformatf("rsp_valid[%0d]", i), RW'(vif.rsp_valid[i]), RW'(m_vld[i]));
        chk($sformatf("rsp_result[%0d]", i), vif.rsp_result[i*RW +: RW], m_res[i]);
        chk($sformatf("rsp_zero[%0d]", i), RW'(vif.rsp_zero[i]), RW'(m_zero[i]));
      end
    end

    if (rst) begin
      m_outst = '0; m_vld = '0; m_zero = '0; m_ptr = 0; m_ex_v = 1'b0;
      for (int i = 0; i < NR; i++) m_res[i] = '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (m_vld[i] && vif.rsp_ready[i]) begin
          if (chk_en) $display("cycle %0d resp req%0d lane0=%0d zero=%0d", cyc, i, m_res[i][31:0], m_zero[i]);
          m_vld[i] = 1'b0;
          m_outst[i] = 1'b0;
        end
      end
      if (m_ex_v) begin
        m_res[m_ex_tag]  = m_ex_out[RW-1:0];
        m_zero[m_ex_tag] = m_ex_out[RW];
        m_vld[m_ex_tag]  = 1'b1;
      end
      if (mg >= 0) begin
        if (chk_en) $display("cycle %0d accept req%0d ctrl=%0d", cyc, mg, vif.req_alu_ctrl[mg*3 +: 3]);
        m_outst[mg] = 1'b1;
        m_ptr       = (mg + 1) % NR;
        m_ex_v      = 1'b1;
        m_ex_tag    = mg;
        m_ex_out    = alu_model(vif.req_a[mg*RW +: RW], vif.req_b[mg*RW +: RW],
                                vif.req_use_imm[mg], vif.req_alu_ctrl[mg*3 +: 3]);
      end else begin
        m_ex_v = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [RW-1:0] a, input logic [RW-1:0] b,
                       input logic imm, input logic [2:0] op);
    vif.req_a[i*RW +: RW]     = a;
    vif.req_b[i*RW +: RW]     = b;
    vif.req_use_imm[i]        = imm;
    vif.req_alu_ctrl[i*3 +: 3] = op;
    vif.req_valid[i]          = 1'b1;
  endtask

  task automatic wait_ready(input int i);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (vif.req_ready[i]) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout req%0d: got no req_ready in 20 cycles, required 1", i);
    end
  endtask

  task automatic issue(input int i, input logic [RW-1:0] a, input logic [RW-1:0] b,
                       input logic imm, input logic [2:0] op);
    step();
    drive(i, a, b, imm, op);
    wait_ready(i);
    step();
    vif.req_valid[i] = 1'b0;
  endtask

  // Called in the cycle after the accept; result is expected two cycles after it.
  task automatic expect_rsp(input string name, input int i, input logic [31:0] lane, input logic zero);
    int n;
    bit ok;
    ok = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (vif.rsp_valid[i]) begin ok = 1'b1; break; end
    end
    chk({name, "_seen"}, RW'(ok), RW'(1));
    chk({name, "_latency"}, RW'(n), RW'(2));
    chk({name, "_result"}, vif.rsp_result[i*RW +: RW], splat(lane));
    chk({name, "_zero"}, RW'(vif.rsp_zero[i]), RW'(zero));
  endtask

  logic [NR-1:0] rr_exp [6];
  int acc1, rsp1;

  initial begin
    vif.req_valid    = '0;
    vif.req_a        = '0;
    vif.req_b        = '0;
    vif.req_use_imm  = '0;
    vif.req_alu_ctrl = '0;
    vif.rsp_ready    = '1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset_rsp_valid", RW'(vif.rsp_valid), RW'(0));
    chk("reset_busy", RW'(vif.busy), RW'(0));
    chk("reset_rsp_result0", vif.rsp_result[0 +: RW], '0);
    step();
    rst = 1'b0;
    repeat (2) step();

    // Single add on req0.
    issue(0, splat(5), splat(3), 1'b0, ALU_ADD);
    expect_rsp("add", 0, 32'd8, 1'b0);

    // Immediate sub to zero on req1; upper B bits are junk and must be ignored.
    issue(1, splat(7), {splat(99)} & ~RW'(32'hFFFF_FFFF) | RW'(32'd7), 1'b1, ALU_SUB);
    expect_rsp("imm_sub", 1, 32'd0, 1'b1);
    repeat (2) step();

    // Round-robin with both requesters continuously valid.
    rr_exp = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    drive(0, splat(1), splat(2), 1'b0, ALU_ADD);
    drive(1, splat(10), splat(20), 1'b0, ALU_ADD);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rr_grant_c%0d", c), RW'(vif.req_ready), RW'(rr_exp[c]));
    end
    step();
    vif.req_valid = '0;
    repeat (4) step();

    // Backpressure on req0 while req1 keeps flowing.
    vif.rsp_ready[0] = 1'b0;
    drive(0, splat(3), splat(4), 1'b0, ALU_MUL);
    wait_ready(0);
    step();
    drive(1, splat(10), splat(4), 1'b0, ALU_SUB);
    @(negedge clk);
    acc1 = 0;
    rsp1 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp_rsp_valid0_c%0d", c), RW'(vif.rsp_valid[0]), RW'(1));
      chk($sformatf("bp_result0_c%0d", c), vif.rsp_result[0 +: RW], splat(12));
      chk($sformatf("bp_ready0_c%0d", c), RW'(vif.req_ready[0]), RW'(0));
      if (vif.req_ready[1]) acc1++;
      if (vif.rsp_valid[1]) rsp1++;
    end
    chk("bp_req1_accepts", RW'(acc1), RW'(3));
    chk("bp_req1_responses", RW'(rsp1), RW'(3));
    step();
    vif.req_valid    = '0;
    vif.rsp_ready[0] = 1'b1;
    repeat (4) step();

    // Opcode sweep on req0.
    issue(0, splat(1), splat(4), 1'b0, ALU_SLL);
    expect_rsp("sll", 0, 32'd16, 1'b0);
    issue(0, splat(2), splat(5), 1'b0, ALU_SLT);
    expect_rsp("slt", 0, 32'd1, 1'b0);
    issue(0, splat(77), splat(9), 1'b0, ALU_REP);
    expect_rsp("rep", 0, 32'd9, 1'b0);
    issue(0, splat(5), splat(3), 1'b0, 3'b111);
    expect_rsp("op111", 0, 32'd0, 1'b1);
    repeat (2) step();

    // Reset in the cycle after an accept drops the operation.
    issue(0, splat(1), splat(1), 1'b0, ALU_ADD);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", RW'(vif.rsp_valid), RW'(0));
    chk("midrst_busy", RW'(vif.busy), RW'(0));
    repeat (3) step();
    drive(0, splat(2), splat(3), 1'b0, ALU_ADD);
    drive(1, splat(4), splat(4), 1'b0, ALU_ADD);
    @(negedge clk);
    chk("post_reset_grant", RW'(vif.req_ready), RW'(2'b01));
    step();
    vif.req_valid = '0;
    expect_rsp("post_reset_add", 0, 32'd5, 1'b0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
